multi_ch_sample_ctrl: RTL and testbench
=======================================

# multi_ch_sample_ctrl

Parametrised, fully synchronous sampling controller for NUM_CH channels, each with NUM_BUF analog sample buffers. It generalises the single-channel state machine to several channels, with per-channel trigger enables and a MODE-selectable buffer group size (1/2/4 buffers per trigger). It also adds a channel-sequenced readout handshake. It sits between the instruction decoder (INST_* pulses) and the per-channel buffer write-enable and readout logic.

## Interface
- NUM_CH, default 4: number of channels, ≥1.
- NUM_BUF, default 4: buffers per channel, power of 2, ≥4.
- CNT_W, default 3: per-channel trigger counter width.
- clk  in  1  system clock; all inputs synchronous to it.
- RST  in  1  synchronous reset, active-high.
- trigger  in  NUM_CH  per-channel trigger level; a rising edge counts.
- ch_enable  in  NUM_CH  channel participation mask, latched on INST_START.
- INST_START, INST_STOP, INST_READOUT  in  1 each  single-cycle instruction pulses.
- MODE  in  2  smode_t: MODE_SAMPLE1=0, MODE_SAMPLE2=1, MODE_SAMPLE4=2; 3 is treated as SAMPLE1. Latched on INST_START.
- RD_DONE  in  1  readout of channel rd_ch is complete, single-cycle pulse.
- current_state  out  2  INIT=0, SAMPLING=1, STOPPED=2, READOUT=3.
- buf_sel  out  NUM_CH*NUM_BUF  per-channel buffer write enables; channel c occupies bits [c*NUM_BUF +: NUM_BUF].
- trigger_cnt  out  NUM_CH*CNT_W  per-channel accepted-trigger count.
- STOP_REQUEST  out  NUM_CH  the channel has filled all its groups.
- rd_ch  out  max(1,$clog2(NUM_CH))  channel under readout.
- rd_active  out  1  high in READOUT while rd_ch is valid.

## Operation
- Group size G = 1, 2 or 4 according to the latched MODE. Groups per channel NG = NUM_BUF/G. Group g is buffers [g*G +: G].
- INIT:
  - All outputs are zero.
  - On INST_START: latch MODE and ch_enable, then go to SAMPLING.
  - INST_STOP, INST_READOUT and RD_DONE are ignored.
- SAMPLING, for each enabled channel:
  - buf_sel drives group trigger_cnt[c] (group 0 on entry).
  - A rising trigger edge increments trigger_cnt[c], advancing to the next group and freezing the previous one.
  - When trigger_cnt[c] reaches NG: buf_sel[c] = 0 and STOP_REQUEST[c] = 1. Further triggers on that channel are ignored.
  - Disabled channels hold buf_sel = 0, count = 0 and STOP_REQUEST = 0.
  - trigger_cnt saturates at 2^CNT_W−1. NG is limited to this value.
- SAMPLING exit: go to STOPPED on INST_STOP, or when STOP_REQUEST covers every enabled channel. With no channels enabled, exit on INST_STOP only. INST_START and INST_READOUT are ignored.
- STOPPED:
  - buf_sel = 0; trigger_cnt and STOP_REQUEST hold.
  - On INST_READOUT: go to READOUT with rd_ch = the lowest enabled channel and rd_active = 1.
  - If no channel is enabled, go to READOUT with rd_active = 0 and return to INIT on the next cycle.
  - INST_START is ignored.
- READOUT:
  - On RD_DONE, rd_ch advances to the next higher enabled channel.
  - On RD_DONE for the highest enabled channel, go to INIT and clear all counters, STOP_REQUEST and rd_ch.
  - All INST_* pulses are ignored.
- Edge detection:
  - A previous-trigger register updates every cycle in every state.
  - A trigger that is already high when SAMPLING is entered does not count.
  - At most one count per channel per cycle.
- Simultaneous events in SAMPLING: when INST_STOP and a trigger edge occur in the same cycle, the trigger is counted and the state goes to STOPPED.
- MODE and ch_enable changes outside INST_START have no effect.

## Timing
- Every output is registered and updates on the clk edge at which the causing input is sampled: 1-cycle latency.
- INST_START sampled at edge k: current_state = SAMPLING and buf_sel group 0 are visible after edge k.
- Trigger edge sampled at edge k (trigger high at k, low at k−1): the new trigger_cnt and buf_sel are visible after k.
- Auto-stop: STOP_REQUEST for the last enabled channel rises after edge k, and current_state = STOPPED after edge k+1.
- RST high at any edge, including mid-SAMPLING or mid-READOUT, forces every output to its reset value after that edge.
  - Reset values: current_state = INIT, all other outputs = 0, previous-trigger register = 0.

## Test plan
- Reset: hold RST 3 cycles mid-SAMPLING -> current_state = 0, buf_sel = 0, trigger_cnt = 0, STOP_REQUEST = 0, rd_active = 0.
- SAMPLE1 fill, NUM_BUF = 4, channel 0 only, one trigger edge at a time:
  - After INST_START: buf_sel[3:0] = 0001.
  - Triggers 1 to 3: buf_sel = 0010, 0100, 1000.
  - 4th trigger: buf_sel = 0000, trigger_cnt = 4, STOP_REQUEST[0] = 1, state = STOPPED one cycle later.
  - 5th trigger: no change.
- SAMPLE2 and SAMPLE4:
  - SAMPLE2: buf_sel[3:0] = 0011 then 1100; auto-stop after 2 triggers.
  - SAMPLE4: buf_sel = 1111; STOP_REQUEST after 1 trigger.
  - Changing MODE mid-SAMPLING leaves the group size unchanged.
- Multi-channel: ch_enable = 0101 in SAMPLE1; trigger channels 0 and 2 with differing counts; triggers on channels 1 and 3 are ignored (count 0).
  - INST_STOP: STOPPED with counts held.
  - INST_READOUT: rd_ch = 0; RD_DONE -> rd_ch = 2; RD_DONE -> INIT with counters cleared.
- Edge cases:
  - Trigger held high across INST_START -> not counted.
  - INST_STOP plus a trigger edge in the same cycle -> count +1, then STOPPED.
  - INST_READOUT in SAMPLING and INST_START in STOPPED -> ignored.
  - ch_enable = 0000 -> INST_STOP, then INST_READOUT, then INIT after 1 cycle with rd_active = 0.

Source files
------------

// File: rtl/multi_ch_sample_ctrl.sv
// Multi-channel sampling controller: per-channel trigger counting into buffer
// groups of 1/2/4, auto-stop when every enabled channel is full, and sequenced readout.
module multi_ch_sample_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int NUM_BUF = 4,
  parameter int CNT_W   = 3
) (
  input  logic                                        clk,
  input  logic                                        RST,
  input  logic [NUM_CH-1:0]                           trigger,
  input  logic [NUM_CH-1:0]                           ch_enable,
  input  logic                                        INST_START,
  input  logic                                        INST_STOP,
  input  logic                                        INST_READOUT,
  input  logic [1:0]                                  MODE,
  input  logic                                        RD_DONE,
  output logic [1:0]                                  current_state,
  output logic [NUM_CH*NUM_BUF-1:0]                   buf_sel,
  output logic [NUM_CH*CNT_W-1:0]                     trigger_cnt,
  output logic [NUM_CH-1:0]                           STOP_REQUEST,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  output logic                                        rd_active
);

  localparam int RD_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {INIT = 2'd0, SAMPLING = 2'd1, STOPPED = 2'd2, READOUT = 2'd3} state_t;
  typedef enum logic [1:0] {MODE_SAMPLE1 = 2'd0, MODE_SAMPLE2 = 2'd1, MODE_SAMPLE4 = 2'd2} smode_t;

  function automatic int grp_size(input logic [1:0] m);
    case (m)
      MODE_SAMPLE2: return 2;
      MODE_SAMPLE4: return 4;
      default:      return 1;
    endcase
  endfunction

  // Group count is capped so a saturating counter can still represent "full".
  function automatic int num_groups(input logic [1:0] m);
    int ng;
    ng = NUM_BUF / grp_size(m);
    return (ng > CNT_MAX) ? CNT_MAX : ng;
  endfunction

  function automatic logic [NUM_BUF-1:0] group_mask(input logic [1:0] m, input logic [CNT_W-1:0] g);
    logic [NUM_BUF-1:0] mask;
    int gs;
    gs   = grp_size(m);
    mask = '0;
    if (int'(g) < num_groups(m))
      for (int b = 0; b < NUM_BUF; b++) mask[b] = ((b / gs) == int'(g));
    return mask;
  endfunction

  state_t                            state_q;
  logic [1:0]                        mode_q;
  logic [NUM_CH-1:0]                 en_q;
  logic [NUM_CH-1:0]                 trig_prev;
  logic [NUM_CH-1:0][CNT_W-1:0]      cnt_q, cnt_n;
  logic [NUM_CH-1:0]                 stop_q, stop_n;
  logic [NUM_CH-1:0][NUM_BUF-1:0]    buf_q;
  logic [RD_W-1:0]                   rd_ch_q, lo_idx, nx_idx;
  logic                              rd_act_q, lo_found, nx_found;
  logic [NUM_CH-1:0]                 rise;
  logic                              all_stopped;
  int                                ng_q;

  // NOTE: every variable gets a default before any conditional write so no latch is inferred.
  always_comb begin
    rise        = trigger & ~trig_prev;
    ng_q        = num_groups(mode_q);
    all_stopped = (en_q != '0) && ((stop_q & en_q) == en_q);
    cnt_n       = cnt_q;
    stop_n      = stop_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state_q == SAMPLING && en_q[c] && rise[c] && int'(cnt_q[c]) < ng_q) begin
        cnt_n[c]  = cnt_q[c] + CNT_W'(1);
        stop_n[c] = (int'(cnt_n[c]) == ng_q);
      end
    end
    lo_found = 1'b0;
    lo_idx   = '0;
    nx_found = 1'b0;
    nx_idx   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (en_q[c]) begin
        lo_found = 1'b1;
        lo_idx   = RD_W'(c);
      end
      if (en_q[c] && c > int'(rd_ch_q)) begin
        nx_found = 1'b1;
        nx_idx   = RD_W'(c);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= INIT;
      mode_q    <= '0;
      en_q      <= '0;
      trig_prev <= '0;
      cnt_q     <= '0;
      stop_q    <= '0;
      buf_q     <= '0;
      rd_ch_q   <= '0;
      rd_act_q  <= 1'b0;
    end else begin
      trig_prev <= trigger;
      case (state_q)
        INIT: begin
          if (INST_START) begin
            mode_q  <= MODE;
            en_q    <= ch_enable;
            state_q <= SAMPLING;
            for (int c = 0; c < NUM_CH; c++)
              buf_q[c] <= ch_enable[c] ? group_mask(MODE, '0) : '0;
          end
        end
        SAMPLING: begin
          cnt_q  <= cnt_n;
          stop_q <= stop_n;
          if (INST_STOP || all_stopped) begin
            state_q <= STOPPED;
            buf_q   <= '0;
          end else begin
            for (int c = 0; c < NUM_CH; c++)
              buf_q[c] <= en_q[c] ? group_mask(mode_q, cnt_n[c]) : '0;
          end
        end
        STOPPED: begin
          if (INST_READOUT) begin
            state_q  <= READOUT;
            rd_ch_q  <= lo_idx;
            rd_act_q <= lo_found;
          end
        end
        READOUT: begin
          if (!rd_act_q || (RD_DONE && !nx_found)) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            stop_q   <= '0;
            rd_ch_q  <= '0;
            rd_act_q <= 1'b0;
          end else if (RD_DONE) begin
            rd_ch_q <= nx_idx;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign current_state = state_q;
  assign buf_sel       = buf_q;
  assign trigger_cnt   = cnt_q;
  assign STOP_REQUEST  = stop_q;
  assign rd_ch         = rd_ch_q;
  assign rd_active     = rd_act_q;

endmodule

// File: tb/tb_multi_ch_sample_ctrl.sv
// Scoreboard bench for multi_ch_sample_ctrl: stimulus queues hand-computed
// expected snapshots after each edge, a negedge monitor pops and compares them.
module tb_multi_ch_sample_ctrl;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  trigger = '0;
  logic [3:0]  ch_enable = '0;
  logic        INST_START = 1'b0, INST_STOP = 1'b0, INST_READOUT = 1'b0, RD_DONE = 1'b0;
  logic [1:0]  MODE = '0;
  logic [1:0]  current_state;
  logic [15:0] buf_sel;
  logic [11:0] trigger_cnt;
  logic [3:0]  STOP_REQUEST;
  logic [1:0]  rd_ch;
  logic        rd_active;

  multi_ch_sample_ctrl #(.NUM_CH(4), .NUM_BUF(4), .CNT_W(3)) dut (
    .clk(clk), .RST(RST), .trigger(trigger), .ch_enable(ch_enable),
    .INST_START(INST_START), .INST_STOP(INST_STOP), .INST_READOUT(INST_READOUT),
    .MODE(MODE), .RD_DONE(RD_DONE), .current_state(current_state), .buf_sel(buf_sel),
    .trigger_cnt(trigger_cnt), .STOP_REQUEST(STOP_REQUEST), .rd_ch(rd_ch), .rd_active(rd_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [15:0] bs;
    logic [11:0] cnt;
    logic [3:0]  sr;
    logic [1:0]  rc;
    logic        ra;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [1:0]  e_st = '0;
  logic [15:0] e_bs = '0;
  logic [11:0] e_cnt = '0;
  logic [3:0]  e_sr = '0;
  logic [1:0]  e_rc = '0;
  logic        e_ra = 1'b0;

  task automatic check(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, "state", 32'(current_state), 32'(e.st));
      check(e.name, "buf_sel", 32'(buf_sel), 32'(e.bs));
      check(e.name, "trigger_cnt", 32'(trigger_cnt), 32'(e.cnt));
      check(e.name, "stop_request", 32'(STOP_REQUEST), 32'(e.sr));
      check(e.name, "rd_ch", 32'(rd_ch), 32'(e.rc));
      check(e.name, "rd_active", 32'(rd_active), 32'(e.ra));
    end
  end

  task automatic tick(input string nm, input bit chk = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    if (chk) begin
      e.name = nm; e.st = e_st; e.bs = e_bs; e.cnt = e_cnt;
      e.sr = e_sr; e.rc = e_rc; e.ra = e_ra;
      sb_q.push_back(e);
    end
  endtask

  task automatic exp_zero();
    e_st = 2'd0; e_bs = '0; e_cnt = '0; e_sr = '0; e_rc = '0; e_ra = 1'b0;
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    tick("rst", 1'b0);
    tick("rst", 1'b0);
    RST = 1'b0;
    exp_zero();
    tick("init_idle");

    // SAMPLE1, channel 0 only
    ch_enable = 4'b0001; MODE = 2'd0; INST_START = 1'b1;
    e_st = 2'd1; e_bs = 16'h0001;
    tick("s1_start");
    INST_START = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      trigger = 4'b0001; e_cnt = 12'(i); e_bs = 16'(1 << i);
      tick("s1_trig");
      trigger = 4'b0000;
      tick("s1_low");
    end
    trigger = 4'b0001; e_cnt = 12'd4; e_bs = '0; e_sr = 4'b0001;
    tick("s1_full");
    trigger = 4'b0000; e_st = 2'd2;
    tick("s1_autostop");
    trigger = 4'b0001;
    tick("s1_extra_trig");
    trigger = 4'b0000;
    tick("s1_extra_low");
    INST_READOUT = 1'b1; e_st = 2'd3; e_rc = 2'd0; e_ra = 1'b1;
    tick("s1_readout");
    INST_READOUT = 1'b0; RD_DONE = 1'b1; exp_zero();
    tick("s1_done");
    RD_DONE = 1'b0;

    // SAMPLE2, with a MODE change mid-sampling
    MODE = 2'd1; INST_START = 1'b1; e_st = 2'd1; e_bs = 16'h0003;
    tick("s2_start");
    INST_START = 1'b0;
    trigger = 4'b0001; e_cnt = 12'd1; e_bs = 16'h000C;
    tick("s2_trig1");
    trigger = 4'b0000; MODE = 2'd2;
    tick("s2_mode_chg");
    trigger = 4'b0001; e_cnt = 12'd2; e_bs = '0; e_sr = 4'b0001;
    tick("s2_full");
    trigger = 4'b0000; e_st = 2'd2;
    tick("s2_autostop");
    INST_READOUT = 1'b1; e_st = 2'd3; e_ra = 1'b1;
    tick("s2_readout");
    INST_READOUT = 1'b0; RD_DONE = 1'b1; exp_zero();
    tick("s2_done");
    RD_DONE = 1'b0;

    // SAMPLE4, plus INST_START ignored in STOPPED
    MODE = 2'd2; INST_START = 1'b1; e_st = 2'd1; e_bs = 16'h000F;
    tick("s4_start");
    INST_START = 1'b0;
    trigger = 4'b0001; e_cnt = 12'd1; e_bs = '0; e_sr = 4'b0001;
    tick("s4_full");
    trigger = 4'b0000; e_st = 2'd2;
    tick("s4_autostop");
    INST_START = 1'b1;
    tick("s4_start_in_stopped");
    INST_START = 1'b0; INST_READOUT = 1'b1; e_st = 2'd3; e_ra = 1'b1;
    tick("s4_readout");
    INST_READOUT = 1'b0; RD_DONE = 1'b1; exp_zero();
    tick("s4_done");
    RD_DONE = 1'b0;

    // Multi-channel 0101, trigger held across start, STOP with coincident edge
    trigger = 4'b0100;
    tick("mc_pre_high");
    ch_enable = 4'b0101; MODE = 2'd0; INST_START = 1'b1; e_st = 2'd1; e_bs = 16'h0101;
    tick("mc_start");
    INST_START = 1'b0; INST_READOUT = 1'b1;
    tick("mc_held_and_readout_ign");
    INST_READOUT = 1'b0; trigger = 4'b0000;
    tick("mc_low");
    trigger = 4'b1111; e_cnt = 12'h041; e_bs = 16'h0202;
    tick("mc_trig_all");
    trigger = 4'b0000;
    tick("mc_low2");
    trigger = 4'b0001; e_cnt = 12'h042; e_bs = 16'h0204;
    tick("mc_trig_ch0");
    trigger = 4'b0000;
    tick("mc_low3");
    trigger = 4'b0100; INST_STOP = 1'b1; e_cnt = 12'h082; e_bs = '0; e_st = 2'd2;
    tick("mc_stop_and_edge");
    trigger = 4'b0000; INST_STOP = 1'b0; INST_READOUT = 1'b1;
    e_st = 2'd3; e_rc = 2'd0; e_ra = 1'b1;
    tick("mc_readout");
    INST_READOUT = 1'b0; RD_DONE = 1'b1; e_rc = 2'd2;
    tick("mc_rd_next");
    RD_DONE = 1'b0;
    tick("mc_rd_hold");
    RD_DONE = 1'b1; exp_zero();
    tick("mc_rd_last");
    RD_DONE = 1'b0;

    // No channels enabled
    ch_enable = 4'b0000; INST_START = 1'b1; e_st = 2'd1;
    tick("ne_start");
    INST_START = 1'b0; trigger = 4'b1111;
    tick("ne_trig_ign");
    trigger = 4'b0000; INST_STOP = 1'b1; e_st = 2'd2;
    tick("ne_stop");
    INST_STOP = 1'b0; INST_READOUT = 1'b1; e_st = 2'd3;
    tick("ne_readout");
    INST_READOUT = 1'b0; e_st = 2'd0;
    tick("ne_back_init");

    // Reset held mid-sampling
    ch_enable = 4'b1111; INST_START = 1'b1; e_st = 2'd1; e_bs = 16'h1111;
    tick("rs_start");
    INST_START = 1'b0; trigger = 4'b1111; e_cnt = 12'h249; e_bs = 16'h2222;
    tick("rs_trig");
    trigger = 4'b0000; RST = 1'b1; exp_zero();
    for (int i = 0; i < 3; i++) tick("rs_reset");
    RST = 1'b0;
    tick("rs_after");

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
